// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit for the E stage: decodes ir_e, latches a
// 64-bit result on mult/multu/div/divu, holds busy for a fixed latency, then
// commits the result to HI/LO. Also services mthi/mtlo/mfhi/mflo.
module muldiv_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] numa,
    input  logic [31:0] numb,
    input  logic [31:0] ir_e,
    output logic        start,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] mdout
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [63:0]      pending;

    logic        is_special;
    logic [5:0]  funct;
    logic        is_mult;
    logic        is_multu;
    logic        is_div;
    logic        is_divu;
    logic        is_mfhi;
    logic        is_mthi;
    logic        is_mflo;
    logic        is_mtlo;
    logic        is_mul_op;
    logic        is_md;
    logic        unused_ir;

    // Instruction decode: only SPECIAL (opcode 0) words with the HI/LO functs matter.
    assign is_special = (ir_e[31:26] == 6'b000000);
    assign funct      = ir_e[5:0];
    assign is_mult    = is_special && (funct == F_MULT);
    assign is_multu   = is_special && (funct == F_MULTU);
    assign is_div     = is_special && (funct == F_DIV);
    assign is_divu    = is_special && (funct == F_DIVU);
    assign is_mfhi    = is_special && (funct == F_MFHI);
    assign is_mthi    = is_special && (funct == F_MTHI);
    assign is_mflo    = is_special && (funct == F_MFLO);
    assign is_mtlo    = is_special && (funct == F_MTLO);
    assign is_mul_op  = is_mult || is_multu;
    assign is_md      = is_mult || is_multu || is_div || is_divu;
    assign unused_ir  = ^ir_e[25:6];

    // A new operation is accepted only when nothing is in flight.
    assign start = is_md && !busy;

    // Move-from path is combinational on the current (possibly stale) HI/LO.
    assign mdout = is_mfhi ? hi : (is_mflo ? lo : 32'd0);

    logic [63:0] a_sx;
    logic [63:0] b_sx;
    logic [63:0] a_zx;
    logic [63:0] b_zx;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [31:0] mag_q;
    logic [31:0] mag_r;
    logic [31:0] sdiv_q;
    logic [31:0] sdiv_r;
    logic [63:0] result;

    // 64-bit result {hi,lo} for the decoded operation; signed divide works on magnitudes.
    always_comb begin
        a_sx   = {{32{numa[31]}}, numa};
        b_sx   = {{32{numb[31]}}, numb};
        a_zx   = {32'd0, numa};
        b_zx   = {32'd0, numb};
        abs_a  = numa[31] ? (32'd0 - numa) : numa;
        abs_b  = numb[31] ? (32'd0 - numb) : numb;
        mag_q  = 32'd0;
        mag_r  = 32'd0;
        if (numb != 32'd0) begin
            mag_q = abs_a / abs_b;
            mag_r = abs_a % abs_b;
        end
        sdiv_q = (numa[31] ^ numb[31]) ? (32'd0 - mag_q) : mag_q;
        sdiv_r = numa[31] ? (32'd0 - mag_r) : mag_r;
        result = 64'd0;
        if (is_mult) begin
            result = a_sx * b_sx;
        end else if (is_multu) begin
            result = a_zx * b_zx;
        end else if (is_div) begin
            if (numb == 32'd0) begin
                result = {numa, 32'hFFFF_FFFF};
            end else begin
                result = {sdiv_r, sdiv_q};
            end
        end else if (is_divu) begin
            if (numb == 32'd0) begin
                result = {numa, 32'hFFFF_FFFF};
            end else begin
                result = {numa % numb, numa / numb};
            end
        end
    end

    // Control FSM, latency counter, pending result and HI/LO registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            busy    <= 1'b0;
            cnt     <= '0;
            pending <= 64'd0;
            hi      <= 32'd0;
            lo      <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        pending <= result;
                        cnt     <= is_mul_op ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                        busy    <= 1'b1;
                        state   <= RUN;
                    end else if (is_mthi) begin
                        hi <= numa;
                    end else if (is_mtlo) begin
                        lo <= numa;
                    end
                end
                RUN: begin
                    if (cnt == CNT_W'(1)) begin
                        hi    <= pending[63:32];
                        lo    <= pending[31:0];
                        busy  <= 1'b0;
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: table of arithmetic vectors through a
// result scoreboard, plus hand sequences for move ops, stalls, back-to-back and reset abort.
module tb_muldiv_unit;

    localparam int unsigned MULT_CYCLES = 5;
    localparam int unsigned DIV_CYCLES  = 10;

    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [31:0] NOP    = 32'h0000_0021;

    logic        clk;
    logic        reset;
    logic [31:0] numa;
    logic [31:0] numb;
    logic [31:0] ir_e;
    logic        start;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] mdout;

    muldiv_unit #(
        .MULT_CYCLES(MULT_CYCLES),
        .DIV_CYCLES (DIV_CYCLES)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .numa (numa),
        .numb (numb),
        .ir_e (ir_e),
        .start(start),
        .busy (busy),
        .hi   (hi),
        .lo   (lo),
        .mdout(mdout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } exp_t;

    typedef struct {
        logic [5:0]  funct;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[10];

    function automatic logic [31:0] rtype(input logic [5:0] f);
        return {26'd0, f};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present an md op for one cycle, expect start, queue its result; returns in T+1.
    task automatic issue(input string name, input logic [5:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                         input int cyc);
        exp_t e;
        ir_e = rtype(f);
        numa = a;
        numb = b;
        #1;
        chk({name, " start"}, 64'(start), 64'd1);
        e.hi     = ehi;
        e.lo     = elo;
        e.cycles = cyc;
        sb.push_back(e);
        step();
        ir_e = NOP;
        numa = 32'd0;
        numb = 32'd0;
    endtask

    // Wait (bounded) for busy to fall, then compare HI/LO and latency against the queue head.
    task automatic drain(input string name, input int already);
        int   n;
        exp_t e;
        n = already;
        while (busy === 1'b1 && n < 100) begin
            n++;
            step();
        end
        if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: scoreboard empty when result appeared", name);
        end else begin
            e = sb.pop_front();
            chk({name, " hi"}, 64'(hi), 64'(e.hi));
            chk({name, " lo"}, 64'(lo), 64'(e.lo));
            chk({name, " busy_cycles"}, 64'(n), 64'(e.cycles));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{F_MULT,  32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA, 5};
        vecs[1] = '{F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5};
        vecs[2] = '{F_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
        vecs[3] = '{F_DIVU,  32'd7,         32'd0,        32'd7,         32'hFFFF_FFFF, 10};
        vecs[4] = '{F_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000, 10};
        vecs[5] = '{F_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,        32'hFFFF_FFFD, 10};
        vecs[6] = '{F_DIVU,  32'd100,       32'd7,        32'd2,         32'd14,        10};
        vecs[7] = '{F_DIV,   32'hFFFF_FFF0, 32'd0,        32'hFFFF_FFF0, 32'hFFFF_FFFF, 10};
        vecs[8] = '{F_MULT,  32'h0000_3039, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_CFC7, 5};
        vecs[9] = '{F_MULTU, 32'h0001_0000, 32'h0001_0000, 32'd1,        32'd0,         5};

        // Reset state and combinational outputs while reset is held.
        reset = 1'b0;
        ir_e  = rtype(F_MULT);
        numa  = 32'd9;
        numb  = 32'd9;
        #2;
        chk("reset hi", 64'(hi), 64'd0);
        chk("reset lo", 64'(lo), 64'd0);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset start", 64'(start), 64'd1);
        ir_e = rtype(F_MFHI);
        #1;
        chk("reset mdout", 64'(mdout), 64'd0);
        ir_e = 32'h8C00_0018;
        #1;
        chk("non_special start", 64'(start), 64'd0);
        ir_e = NOP;
        numa = 32'd0;
        numb = 32'd0;
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b1;
        step();

        // Table-driven arithmetic through the scoreboard.
        for (int i = 0; i < 10; i++) begin
            issue($sformatf("vec%0d", i), vecs[i].funct, vecs[i].a, vecs[i].b,
                  vecs[i].hi, vecs[i].lo, vecs[i].cycles);
            drain($sformatf("vec%0d", i), 0);
        end

        // mthi/mtlo then mfhi/mflo.
        ir_e = rtype(F_MTHI);
        numa = 32'h1234_5678;
        step();
        ir_e = rtype(F_MFHI);
        #1;
        chk("mthi_mfhi mdout", 64'(mdout), 64'h1234_5678);
        ir_e = rtype(F_MTLO);
        numa = 32'hCAFE_BABE;
        step();
        ir_e = rtype(F_MFLO);
        #1;
        chk("mtlo_mflo mdout", 64'(mdout), 64'hCAFE_BABE);
        ir_e = NOP;
        numa = 32'd0;
        #1;
        chk("nop mdout", 64'(mdout), 64'd0);

        // During RUN: stale mfhi, ignored mthi, rejected second mult.
        issue("run_seq", F_MULT, 32'd2, 32'd3, 32'd0, 32'd6, 5);
        ir_e = rtype(F_MFHI);
        #1;
        chk("run mfhi stale", 64'(mdout), 64'h1234_5678);
        chk("run busy", 64'(busy), 64'd1);
        step();
        ir_e = rtype(F_MTHI);
        numa = 32'hDEAD_BEEF;
        #1;
        chk("run mthi start", 64'(start), 64'd0);
        step();
        chk("run mthi ignored", 64'(hi), 64'h1234_5678);
        ir_e = rtype(F_MULT);
        numa = 32'd5;
        numb = 32'd5;
        #1;
        chk("run mult start", 64'(start), 64'd0);
        step();
        ir_e = NOP;
        numa = 32'd0;
        numb = 32'd0;
        drain("run_seq", 3);

        // Back-to-back: div issued in the first idle cycle after a mult.
        issue("b2b_mult", F_MULT, 32'd3, 32'd4, 32'd0, 32'd12, 5);
        drain("b2b_mult", 0);
        issue("b2b_div", F_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 10);
        for (int i = 0; i < int'(DIV_CYCLES) - 1; i++) begin
            chk($sformatf("b2b hold %0d", i), {hi, lo}, {32'd0, 32'd12});
            step();
        end
        drain("b2b_div", int'(DIV_CYCLES) - 1);

        // Asynchronous reset at T+3 of a div aborts it.
        ir_e = rtype(F_DIV);
        numa = 32'd50;
        numb = 32'd3;
        #1;
        chk("abort start", 64'(start), 64'd1);
        step();
        ir_e = NOP;
        numa = 32'd0;
        numb = 32'd0;
        step();
        step();
        reset = 1'b0;
        #1;
        chk("abort hi", 64'(hi), 64'd0);
        chk("abort lo", 64'(lo), 64'd0);
        chk("abort busy", 64'(busy), 64'd0);
        #3;
        reset = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            chk($sformatf("post_abort %0d", i), {31'd0, busy, hi, lo}, 96'd0);
        end
        issue("post_abort_mult", F_MULT, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
        drain("post_abort_mult", 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Multi-cycle multiply/divide unit for the E stage of the pipelined MIPS core, alongside the ALU. It decodes the E-stage instruction word itself, the same way the ALU does. It latches operands on mult/multu/div/divu, holds `busy` for a fixed latency, and then commits the 64-bit result to HI/LO. It services mthi/mtlo/mfhi/mflo and gives the hazard unit `start`/`busy` so it can stall dependent instructions in D.

## Interface
- MULT_CYCLES, 5, busy cycles for mult/multu (≥1)
- DIV_CYCLES, 10, busy cycles for div/divu (≥1)

- clk  input  1  sole clock, rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset)
- numa  input  32  rs operand (forwarded), E stage
- numb  input  32  rt operand (forwarded), E stage
- ir_e  input  32  E-stage instruction word
- start  output  1  combinational: ir_e is mult/multu/div/divu and busy==0
- busy  output  1  registered: operation in flight
- hi  output  32  HI register
- lo  output  32  LO register
- mdout  output  32  combinational: hi if ir_e is mfhi, lo if mflo, else 0

## Operation
- Decode (op=000000, funct): mult 011000, multu 011001, div 011010, divu 011011, mfhi 010000, mthi 010001, mflo 010010, mtlo 010011. All other words are no-ops for this block.
- States:
  - IDLE (busy=0).
  - RUN (busy=1, down-counter cnt).
- IDLE, start=1, at the clock edge:
  - Compute the 64-bit result from numa/numb into a pending register.
  - Set cnt to MULT_CYCLES or DIV_CYCLES.
  - Go to RUN.
  - HI/LO are unchanged.
- RUN, at each edge: cnt decrements. The edge where cnt==1 writes the pending result to HI/LO, clears busy, and returns to IDLE.
- mthi/mtlo in IDLE write numa to hi/lo at the edge. mthi/mtlo in RUN are ignored; the hazard unit never issues them then.
- mult/div in RUN: start=0 and nothing is latched. The pipeline stalls the instruction in D, so this is a protocol violation with no effect.
- mfhi/mflo: mdout always reflects the current HI/LO, including during RUN (stale values). The hazard unit stalls mfhi/mflo while start|busy.
- Arithmetic:
  - mult: signed 32×32 → 64, {hi,lo}.
  - multu: unsigned 32×32 → 64, {hi,lo}.
  - div: lo=quotient truncated toward zero, hi=remainder with the sign of the dividend (numa).
  - divu: unsigned lo=numa/numb, hi=numa%numb.
- Boundary cases:
  - Divide by zero (div or divu): lo=32'hFFFF_FFFF, hi=numa.
  - div 32'h8000_0000 / 32'hFFFF_FFFF: lo=32'h8000_0000, hi=0.
- Reset (any time, including mid-RUN): hi=0, lo=0, busy=0, cnt=0, pending=0, state IDLE. The in-flight result is discarded.

## Timing
- Let T be the cycle where ir_e holds mult (or other md op) with busy=0, so start=1 in T.
  - busy=1 during T+1 .. T+MULT_CYCLES.
  - New hi/lo are visible from T+MULT_CYCLES+1, the same cycle busy falls.
  - Div is identical with DIV_CYCLES.
- A new mult/div may start in the first cycle busy==0 (back-to-back). Its result never overlaps the previous one.
- mthi/mtlo take effect the cycle after issue. mdout has zero latency (combinational on ir_e, hi, lo).
- Reset outputs: start follows ir_e combinationally with busy=0. mdout is 0 unless ir_e is mfhi/mflo, in which case it shows 0 from the cleared HI/LO.

## Test plan
- mult numa=32'hFFFF_FFFE (−2), numb=3 → start=1 in T; busy high T+1..T+5; at T+6 hi=32'hFFFF_FFFF, lo=32'hFFFF_FFFA.
- multu 32'hFFFF_FFFF × 32'hFFFF_FFFF → after 5 busy cycles, hi=32'hFFFF_FFFE, lo=32'h0000_0001.
- div −7 / 2 → busy 10 cycles, then lo=32'hFFFF_FFFD (−3), hi=32'hFFFF_FFFF (−1). divu 7/0 → lo=32'hFFFF_FFFF, hi=7. div 32'h8000_0000 / −1 → lo=32'h8000_0000, hi=0.
- mthi numa=32'h1234_5678 then mfhi next cycle → mdout=32'h1234_5678.
  - mthi issued while busy → hi unchanged.
  - mfhi during RUN → old hi on mdout.
- Back-to-back: mult then div issued in the first cycle busy==0 → div result lands 10 cycles later and mult result is intact until then. A mult presented while busy → start=0 and no state change.
- Assert reset (low) at T+3 of a div → hi/lo=0 and busy=0 immediately (asynchronously). After release, a mult starts normally and the aborted div never writes HI/LO.
